prefix_adder_pipe: RTL and testbench

Parametrised, pipelined parallel-prefix adder/subtractor with a valid/ready handshake on both sides. It generalises the team's fixed 16-bit combinational prefix adder to any power-of-two width, a configurable register depth, carry-in, subtract mode and signed-overflow reporting. It sits between an operand-issue stage and a result consumer that may apply backpressure.

---
 rtl/prefix_adder_pipe_if.sv | 27 ++
 rtl/prefix_adder_pipe.sv | 121 ++++++++++++
 tb/tb_prefix_adder_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result handshake bundle for prefix_adder_pipe.
// The master side issues operands and consumes results; the slave side is the adder.
interface prefix_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control.
// PIPE register stages are spread evenly over the log2(WIDTH) prefix levels; the last one holds the result.
module prefix_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input logic                clk,
  input logic                rst_n,
  prefix_adder_pipe_if.slave bus
);
  localparam int L    = $clog2(WIDTH);
  localparam int NMID = (PIPE > 1) ? PIPE - 1 : 1;

  typedef struct packed {
    logic [WIDTH-1:0] p;   // bitwise propagate, kept until the final sum XOR
    logic             c0;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] gp;
  } pf_t;

  // Register s+1 sits after prefix level last_level(s); the final stage runs to level L.
  function automatic int last_level(input int s);
    return (s == PIPE - 1) ? L : ((s + 1) * L) / PIPE;
  endfunction

  function automatic int first_level(input int s);
    return (s == 0) ? 1 : last_level(s - 1) + 1;
  endfunction

  // Applies Sklansky levels lo..hi; an empty range passes the operands through.
  function automatic pf_t prefix_levels(input pf_t x, input int lo, input int hi);
    pf_t y;
    int  j;
    y = x;
    for (int l = 1; l <= L; l++) begin
      if (l >= lo && l <= hi) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> (l - 1)) & 1) == 1) begin
            // j is the top bit of the neighbouring aligned block; it is not updated at this level.
            j = ((i >> (l - 1)) << (l - 1)) - 1;
            y.gg[i] = y.gg[i] | (y.gp[i] & y.gg[j]);
            y.gp[i] = y.gp[i] & y.gp[j];
          end
        end
      end
    end
    return y;
  endfunction

  logic [WIDTH-1:0] b_eff;
  pf_t              pre;
  pf_t              stage_out [PIPE];
  pf_t              mid_q     [NMID];
  logic [PIPE-1:0]  vld_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             en;

  // NOTE: every field of pre is assigned on every pass, so no latch can be inferred here.
  always_comb begin
    b_eff      = bus.sub ? ~bus.b : bus.b;
    pre.c0     = bus.cin ^ bus.sub;
    pre.p      = bus.a ^ b_eff;
    pre.gp     = bus.a ^ b_eff;
    pre.gg     = bus.a & b_eff;
    pre.gg[0]  = pre.gg[0] | (pre.p[0] & pre.c0);
  end

  always_comb begin
    for (int s = 0; s < PIPE; s++) begin
      stage_out[s] = prefix_levels((s == 0) ? pre : mid_q[(s == 0) ? 0 : s - 1],
                                   first_level(s), last_level(s));
    end
  end

  // Carry into bit i is the group generate of bits i-1..0; bit 0 takes c0 directly.
  always_comb begin
    sum_d  = stage_out[PIPE-1].p ^ {stage_out[PIPE-1].gg[WIDTH-2:0], stage_out[PIPE-1].c0};
    cout_d = stage_out[PIPE-1].gg[WIDTH-1];
    ovf_d  = stage_out[PIPE-1].gg[WIDTH-2] ^ stage_out[PIPE-1].gg[WIDTH-1];
  end

  // One global enable: the whole pipe advances or the whole pipe holds.
  assign en           = ~vld_q[PIPE-1] | bus.out_ready;
  assign bus.in_ready = en;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      for (int s = 0; s < PIPE; s++) begin
        vld_q[s] <= (s == 0) ? bus.in_valid : vld_q[(s == 0) ? 0 : s - 1];
      end
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  // NOTE: intermediate data registers carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int s = 0; s < NMID; s++) begin
        mid_q[s] <= stage_out[s];
      end
    end
  end

  assign bus.out_valid = vld_q[PIPE-1];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and model-checked bench for prefix_adder_pipe: a 16-bit/2-stage instance for
// handshake scenarios, plus a width/depth sweep driven in lockstep from shared stimulus.
module tb_prefix_adder_pipe;
  localparam int P16 = 2;
  localparam int NS  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prefix_adder_pipe_if #(.WIDTH(16)) m16 ();
  prefix_adder_pipe #(.WIDTH(16), .PIPE(P16)) u16 (.clk(clk), .rst_n(rst_n), .bus(m16));

  prefix_adder_pipe_if #(.WIDTH(4))  s0 ();
  prefix_adder_pipe_if #(.WIDTH(4))  s1 ();
  prefix_adder_pipe_if #(.WIDTH(32)) s2 ();
  prefix_adder_pipe_if #(.WIDTH(64)) s3 ();
  prefix_adder_pipe #(.WIDTH(4),  .PIPE(1)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(s0));
  prefix_adder_pipe #(.WIDTH(4),  .PIPE(3)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(s1));
  prefix_adder_pipe #(.WIDTH(32), .PIPE(1)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(s2));
  prefix_adder_pipe #(.WIDTH(64), .PIPE(7)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(s3));

  logic        st_valid, st_cin, st_sub, st_ready;
  logic [63:0] st_a, st_b;

  assign s0.in_valid = st_valid;  assign s0.a = st_a[3:0];  assign s0.b = st_b[3:0];
  assign s0.cin = st_cin;  assign s0.sub = st_sub;  assign s0.out_ready = st_ready;
  assign s1.in_valid = st_valid;  assign s1.a = st_a[3:0];  assign s1.b = st_b[3:0];
  assign s1.cin = st_cin;  assign s1.sub = st_sub;  assign s1.out_ready = st_ready;
  assign s2.in_valid = st_valid;  assign s2.a = st_a[31:0]; assign s2.b = st_b[31:0];
  assign s2.cin = st_cin;  assign s2.sub = st_sub;  assign s2.out_ready = st_ready;
  assign s3.in_valid = st_valid;  assign s3.a = st_a;       assign s3.b = st_b;
  assign s3.cin = st_cin;  assign s3.sub = st_sub;  assign s3.out_ready = st_ready;

  logic [NS-1:0] sw_ov, sw_co, sw_of;
  logic [63:0]   sw_sum [NS];

  assign sw_ov = {s3.out_valid, s2.out_valid, s1.out_valid, s0.out_valid};
  assign sw_co = {s3.cout, s2.cout, s1.cout, s0.cout};
  assign sw_of = {s3.ovf, s2.ovf, s1.ovf, s0.ovf};
  assign sw_sum[0] = 64'(s0.sum);
  assign sw_sum[1] = 64'(s1.sum);
  assign sw_sum[2] = 64'(s2.sum);
  assign sw_sum[3] = s3.sum;

  function automatic int sw_w(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int sw_p(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 1;
      default: return 7;
    endcase
  endfunction

  // Golden result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb);
    logic [63:0]        mask, am, bm, s;
    logic [64:0]        full;
    logic               co, of;
    logic signed [65:0] sa, sbv, r, lim, cis;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    if (!sb) begin
      full = {1'b0, am} + {1'b0, bm} + {64'd0, ci};
      s    = full[63:0] & mask;
      co   = full[w];
    end else begin
      s  = (am - bm - {63'd0, ci}) & mask;
      co = ({1'b0, am} >= ({1'b0, bm} + {64'd0, ci}));
    end
    sa  = {2'b00, am};
    sbv = {2'b00, bm};
    if (am[w-1]) sa = sa - (66'sd1 <<< w);
    if (bm[w-1]) sbv = sbv - (66'sd1 <<< w);
    cis = {65'd0, ci};
    r   = sb ? (sa - sbv - cis) : (sa + sbv + cis);
    lim = 66'sd1 <<< (w - 1);
    of  = (r >= lim) || (r < -lim);
    return {of, co, s};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    m16.in_valid = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0; m16.sub = 1'b0;
    m16.out_ready = 1'b1;
    st_valid = 1'b0; st_a = '0; st_b = '0; st_cin = 1'b0; st_sub = 1'b0; st_ready = 1'b1;
    #12;
    checks++;
    if (m16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", m16.out_valid); end
    checks++;
    if (m16.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", m16.sum); end
    checks++;
    if ({m16.cout, m16.ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b want 00", {m16.cout, m16.ovf}); end
    checks++;
    if (m16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", m16.in_ready); end
    checks++;
    if (sw_ov !== '0) begin errors++; $display("FAIL reset_sweep_valid: got %b want 0000", sw_ov); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] va [6], vb [6], es [6];
    logic        vc [6], vs [6], eco [6], eov [6];
    int          idx;
    va  = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0000, 16'h0005};
    vb  = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0003};
    vc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es  = '{16'h0000, 16'h8000, 16'h1236, 16'h7FFF, 16'hFFFF, 16'h0001};
    eco = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eov = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i <= 6 + P16; i++) begin
      idx = i - P16;
      checks++;
      if (idx >= 0 && idx < 6) begin
        if ({m16.out_valid, m16.sum, m16.cout, m16.ovf} !== {1'b1, es[idx], eco[idx], eov[idx]}) begin
          errors++;
          $display("FAIL directed_%0d: got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                   idx, m16.out_valid, m16.sum, m16.cout, m16.ovf, es[idx], eco[idx], eov[idx]);
        end
      end else if (m16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_latency cyc %0d: got out_valid=%b want 0", i, m16.out_valid);
      end
      if (i < 6) begin
        m16.in_valid = 1'b1; m16.a = va[i]; m16.b = vb[i]; m16.cin = vc[i]; m16.sub = vs[i];
      end else begin
        m16.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 100;
    logic [15:0] ra [N], rb [N];
    logic        rc [N], rs [N];
    logic [65:0] mr;
    int          idx;
    for (int i = 0; i < N; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);  rs[i] = 1'($urandom);
    end
    for (int i = 0; i <= N + P16; i++) begin
      idx = i - P16;
      checks++;
      if (idx >= 0 && idx < N) begin
        mr = model(16, 64'(ra[idx]), 64'(rb[idx]), rc[idx], rs[idx]);
        if ({m16.out_valid, m16.ovf, m16.cout, m16.sum} !== {1'b1, mr[65:64], mr[15:0]}) begin
          errors++;
          $display("FAIL stream_%0d: got v=%b o=%b c=%b sum=%h want v=1 o=%b c=%b sum=%h",
                   idx, m16.out_valid, m16.ovf, m16.cout, m16.sum, mr[65], mr[64], mr[15:0]);
        end
      end else if (m16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_latency cyc %0d: got out_valid=%b want 0", i, m16.out_valid);
      end
      if (i < N) begin
        m16.in_valid = 1'b1; m16.a = ra[i]; m16.b = rb[i]; m16.cin = rc[i]; m16.sub = rs[i];
      end else begin
        m16.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [17:0] exp_q [$];
    logic [17:0] held, want;
    logic [65:0] mr;
    logic        holding;
    int          sent, got;
    sent = 0; got = 0; holding = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      if (holding) begin
        checks++;
        if (m16.out_valid !== 1'b1 || {m16.ovf, m16.cout, m16.sum} !== held) begin
          errors++;
          $display("FAIL bp_hold cyc %0d: got v=%b %h want v=1 %h", cyc, m16.out_valid,
                   {m16.ovf, m16.cout, m16.sum}, held);
        end
      end
      m16.out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 10) begin
        m16.in_valid = 1'b1;
        m16.a = 16'(sent * 4951 + 240); m16.b = 16'(sent * 7919 + 3);
        m16.cin = sent[0]; m16.sub = sent[1];
      end else begin
        m16.in_valid = 1'b0;
      end
      #1;
      holding = m16.out_valid && !m16.out_ready;
      if (holding) begin
        held = {m16.ovf, m16.cout, m16.sum};
        checks++;
        if (m16.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d: got %b want 0", cyc, m16.in_ready); end
      end
      if (m16.out_valid && m16.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat cyc %0d: got %h want none", cyc, {m16.ovf, m16.cout, m16.sum});
        end else begin
          want = exp_q.pop_front();
          if ({m16.ovf, m16.cout, m16.sum} !== want) begin
            errors++;
            $display("FAIL bp_order beat %0d: got %h want %h", got, {m16.ovf, m16.cout, m16.sum}, want);
          end
        end
        got++;
      end
      if (m16.in_valid && m16.in_ready) begin
        mr = model(16, 64'(m16.a), 64'(m16.b), m16.cin, m16.sub);
        exp_q.push_back({mr[65:64], mr[15:0]});
        sent++;
      end
    end
    checks++;
    if (got != 10 || sent != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got sent=%0d drained=%0d left=%0d want 10 10 0", sent, got, exp_q.size());
    end
    @(negedge clk);
    m16.in_valid = 1'b0; m16.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    m16.in_valid = 1'b1; m16.a = 16'h1234; m16.b = 16'h1111; m16.cin = 1'b0; m16.sub = 1'b0;
    @(negedge clk);
    m16.a = 16'h0F0F; m16.b = 16'h0101;
    @(negedge clk);
    m16.in_valid = 1'b0;
    checks++;
    if ({m16.out_valid, m16.sum} !== {1'b1, 16'h2345}) begin
      errors++;
      $display("FAIL rst_pre: got v=%b sum=%h want v=1 sum=2345", m16.out_valid, m16.sum);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m16.out_valid, m16.sum, m16.cout, m16.ovf} !== 19'd0) begin
      errors++;
      $display("FAIL rst_async: got v=%b sum=%h c=%b o=%b want all 0", m16.out_valid, m16.sum, m16.cout, m16.ovf);
    end
    checks++;
    if (m16.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", m16.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (m16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc %0d: got out_valid=%b want 0", i, m16.out_valid); end
    end
  endtask

  task automatic test_sweep;
    localparam int NX = 1024;
    localparam int N  = NX + 40;
    logic [63:0] xa [N], xb [N];
    logic        xc [N], xs [N];
    logic [65:0] want;
    int          idx;
    for (int i = 0; i < N; i++) begin
      if (i < NX) begin
        xa[i] = 64'(i % 16); xb[i] = 64'((i / 16) % 16);
        xc[i] = 1'((i / 256) % 2); xs[i] = 1'((i / 512) % 2);
      end else begin
        xa[i] = {$urandom, $urandom}; xb[i] = {$urandom, $urandom};
        xc[i] = 1'($urandom); xs[i] = 1'($urandom);
      end
    end
    xa[NX] = '1;        xb[NX] = 64'd1;     xc[NX] = 1'b0;     xs[NX] = 1'b0;
    xa[NX+1] = {1'b1, 63'd0}; xb[NX+1] = 64'd1; xc[NX+1] = 1'b0; xs[NX+1] = 1'b1;
    for (int i = 0; i <= N + 7; i++) begin
      for (int k = 0; k < NS; k++) begin
        idx = i - sw_p(k);
        checks++;
        if (idx >= 0 && idx < N) begin
          want = model(sw_w(k), xa[idx], xb[idx], xc[idx], xs[idx]);
          if ({sw_ov[k], sw_of[k], sw_co[k], sw_sum[k]} !== {1'b1, want}) begin
            errors++;
            $display("FAIL sweep_w%0d_p%0d beat %0d: got v=%b o=%b c=%b sum=%h want v=1 o=%b c=%b sum=%h",
                     sw_w(k), sw_p(k), idx, sw_ov[k], sw_of[k], sw_co[k], sw_sum[k], want[65], want[64], want[63:0]);
          end
        end else if (sw_ov[k] !== 1'b0) begin
          errors++;
          $display("FAIL sweep_latency_w%0d_p%0d cyc %0d: got out_valid=%b want 0", sw_w(k), sw_p(k), i, sw_ov[k]);
        end
      end
      if (i < N) begin
        st_valid = 1'b1; st_a = xa[i]; st_b = xb[i]; st_cin = xc[i]; st_sub = xs[i];
      end else begin
        st_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
